// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: RV32I multicycle control FSM driving datapath muxes, enables and ALU op.
// Optional MCTRL_ILLEGAL_TRAP_EN: illegal encodings park in TRAP with a sticky illegal flag.
module multicycle_ctrl #(
  parameter int MEM_LATENCY = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  output logic       pc_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] imm_src,
  output logic [2:0] alu_control,
  output logic       illegal
);
  localparam int W = $clog2(MEM_LATENCY + 1);
  localparam logic [W-1:0] LAST = W'(MEM_LATENCY - 1);
  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
    EXECR, EXECI, ALUWB, BEQ, JAL, TRAP
  } state_t;
`ifdef MCTRL_ILLEGAL_TRAP_EN
  localparam state_t BAD = TRAP;
`else
  localparam state_t BAD = FETCH;
`endif
  state_t state, next;
  logic [W-1:0] wait_cnt;
  logic last, alu_ok, pc_w, mem_w, ir_w, reg_w;
  logic [2:0] alu_op;
  assign last = wait_cnt == LAST;
  assign alu_ok = funct3 == 3'b000 || funct3 == 3'b010 || funct3[2:1] == 2'b11;
  assign alu_op = funct3 == 3'b010 ? 3'b101 :
                  funct3 == 3'b110 ? 3'b011 :
                  funct3 == 3'b111 ? 3'b010 :
                  (state == EXECR && funct7b5) ? 3'b001 : 3'b000;
  // Write enables are masked during reset so the reset cycle never commits state.
  assign pc_write  = pc_w & ~reset;
  assign mem_write = mem_w & ~reset;
  assign ir_write  = ir_w & ~reset;
  assign reg_write = reg_w & ~reset;
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= FETCH;
      wait_cnt <= '0;
    end else begin
      state    <= next;
      wait_cnt <= next != state ? '0 : wait_cnt + W'(!last);
    end
  end
  always_comb begin
    next        = state;
    pc_w        = 1'b0;
    mem_w       = 1'b0;
    ir_w        = 1'b0;
    reg_w       = 1'b0;
    adr_src     = 1'b0;
    result_src  = 2'b00;
    alu_src_a   = 2'b00;
    alu_src_b   = 2'b00;
    imm_src     = 2'b00;
    alu_control = 3'b000;
    case (state)
      FETCH: begin
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        pc_w       = last;
        ir_w       = last;
        next       = last ? DECODE : FETCH;
      end
      DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        imm_src   = 2'b10;
        case (op)
          7'b0000011, 7'b0100011: next = MEMADR;
          7'b0110011: next = alu_ok ? EXECR : BAD;
          7'b0010011: next = alu_ok ? EXECI : BAD;
          7'b1100011: next = funct3 == 3'b000 ? BEQ : BAD;
          7'b1101111: next = JAL;
          default:    next = BAD;
        endcase
      end
      MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        imm_src   = op[5] ? 2'b01 : 2'b00;
        next      = op[5] ? MEMWRITE : MEMREAD;
      end
      MEMREAD: begin
        adr_src = 1'b1;
        next    = last ? MEMWB : MEMREAD;
      end
      MEMWB: begin
        result_src = 2'b01;
        reg_w      = 1'b1;
        next       = FETCH;
      end
      MEMWRITE: begin
        adr_src = 1'b1;
        mem_w   = 1'b1;
        next    = FETCH;
      end
      EXECR: begin
        alu_src_a   = 2'b10;
        alu_control = alu_op;
        next        = ALUWB;
      end
      EXECI: begin
        alu_src_a   = 2'b10;
        alu_src_b   = 2'b01;
        alu_control = alu_op;
        next        = ALUWB;
      end
      ALUWB: begin
        reg_w = 1'b1;
        next  = FETCH;
      end
      BEQ: begin
        alu_src_a   = 2'b10;
        alu_control = 3'b001;
        pc_w        = zero;
        next        = FETCH;
      end
      JAL: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_w      = 1'b1;
        next      = ALUWB;
      end
      TRAP:    next = TRAP;
      default: next = FETCH;
    endcase
  end
`ifdef MCTRL_ILLEGAL_TRAP_EN
  logic ill_q;
  always_ff @(posedge clk) ill_q <= reset ? 1'b0 : ill_q | (next == TRAP);
  assign illegal = ill_q;
`else
  assign illegal = 1'b0;
`endif
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: table-driven scoreboard bench for multicycle_ctrl at MEM_LATENCY 1, 3 and 4.
module tb_multicycle_ctrl;
  typedef struct packed {
    logic [6:0]       op;
    logic [2:0]       f3;
    logic             f7;
    logic             z;
    logic [2:0]       n;
    logic [4:0][16:0] e;
  } vec_t;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst [3];
  logic [6:0] op;
  logic [2:0] funct3;
  logic funct7b5, zero;
  logic pw [3], ad [3], mw [3], iw [3], rw [3], il [3];
  logic [1:0] rs [3], sa [3], sb [3], imm [3];
  logic [2:0] ac [3];
  int pass = 0, total = 0;
  logic [16:0] q [$];
  vec_t tbl [12];
  logic [16:0] F, FN, D, MAL, MAS, MR, MWB, MW, AWB, J, TR;
  multicycle_ctrl #(.MEM_LATENCY(1)) d1 (.clk(clk), .reset(rst[0]), .op(op), .funct3(funct3),
    .funct7b5(funct7b5), .zero(zero), .pc_write(pw[0]), .adr_src(ad[0]), .mem_write(mw[0]),
    .ir_write(iw[0]), .reg_write(rw[0]), .result_src(rs[0]), .alu_src_a(sa[0]), .alu_src_b(sb[0]),
    .imm_src(imm[0]), .alu_control(ac[0]), .illegal(il[0]));
  multicycle_ctrl #(.MEM_LATENCY(3)) d3 (.clk(clk), .reset(rst[1]), .op(op), .funct3(funct3),
    .funct7b5(funct7b5), .zero(zero), .pc_write(pw[1]), .adr_src(ad[1]), .mem_write(mw[1]),
    .ir_write(iw[1]), .reg_write(rw[1]), .result_src(rs[1]), .alu_src_a(sa[1]), .alu_src_b(sb[1]),
    .imm_src(imm[1]), .alu_control(ac[1]), .illegal(il[1]));
  multicycle_ctrl #(.MEM_LATENCY(4)) d4 (.clk(clk), .reset(rst[2]), .op(op), .funct3(funct3),
    .funct7b5(funct7b5), .zero(zero), .pc_write(pw[2]), .adr_src(ad[2]), .mem_write(mw[2]),
    .ir_write(iw[2]), .reg_write(rw[2]), .result_src(rs[2]), .alu_src_a(sa[2]), .alu_src_b(sb[2]),
    .imm_src(imm[2]), .alu_control(ac[2]), .illegal(il[2]));
  // Expected word layout: {pc_write,adr_src,mem_write,ir_write,reg_write,result_src,alu_src_a,alu_src_b,imm_src,alu_control,illegal}
  function automatic logic [16:0] w(input logic pc, adr, mwe, ir, rwe, input logic [1:0] r, a, b, i,
                                    input logic [2:0] c, input logic l);
    return {pc, adr, mwe, ir, rwe, r, a, b, i, c, l};
  endfunction
  function automatic logic [16:0] act(input int i);
    return {pw[i], ad[i], mw[i], iw[i], rw[i], rs[i], sa[i], sb[i], imm[i], ac[i], il[i]};
  endfunction
  function automatic logic [16:0] er(input logic [2:0] c);
    return w(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b00, c, 0);
  endfunction
  function automatic logic [16:0] ei(input logic [2:0] c);
    return w(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, c, 0);
  endfunction
  function automatic logic [16:0] bq(input logic z);
    return w(z, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b00, 3'b001, 0);
  endfunction
  function automatic vec_t mk(input logic [6:0] o, input logic [2:0] f, input logic s, z,
                              input logic [2:0] n, input logic [16:0] e0, e1, e2, e3, e4);
    vec_t v;
    v.op = o; v.f3 = f; v.f7 = s; v.z = z; v.n = n;
    v.e[0] = e0; v.e[1] = e1; v.e[2] = e2; v.e[3] = e3; v.e[4] = e4;
    return v;
  endfunction
  task automatic chk(input string nm, input int k, input logic [16:0] a, input logic [16:0] e);
    total++;
    if (a === e) pass++;
    else $display("FAIL %s cycle %0d: got %b expected %b", nm, k, a, e);
  endtask
  task automatic run(input string nm, input int dut, input int n);
    for (int k = 0; k < n; k++) begin
      #1 chk(nm, k, act(dut), q.pop_front());
      @(negedge clk);
    end
  endtask
  task automatic ill_seq(input string nm, input logic [6:0] o, input logic [2:0] f);
    op = o; funct3 = f;
    q.push_back(F); q.push_back(D);
`ifdef MCTRL_ILLEGAL_TRAP_EN
    q.push_back(TR); q.push_back(TR);
    run(nm, 0, 4);
    rst[0] = 1'b1;
    q.push_back(TR);
`else
    q.push_back(F);
    run(nm, 0, 3);
    rst[0] = 1'b1;
    q.push_back(D);
`endif
    q.push_back(FN);
    run({nm, "_rst"}, 0, 2);
    rst[0] = 1'b0;
  endtask
  initial begin
    F   = w(1, 0, 0, 1, 0, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000, 0);
    FN  = w(0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000, 0);
    D   = w(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b10, 3'b000, 0);
    MAL = w(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 3'b000, 0);
    MAS = w(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b01, 3'b000, 0);
    MR  = w(0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0);
    MWB = w(0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 2'b00, 3'b000, 0);
    MW  = w(0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0);
    AWB = w(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0);
    J   = w(1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 2'b00, 3'b000, 0);
    TR  = w(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 1);
    tbl[0]  = mk(7'b0000011, 3'b010, 0, 1, 5, F, D, MAL, MR, MWB);
    tbl[1]  = mk(7'b0100011, 3'b010, 0, 1, 4, F, D, MAS, MW, 0);
    tbl[2]  = mk(7'b0110011, 3'b000, 0, 1, 4, F, D, er(3'b000), AWB, 0);
    tbl[3]  = mk(7'b0110011, 3'b000, 1, 1, 4, F, D, er(3'b001), AWB, 0);
    tbl[4]  = mk(7'b0110011, 3'b010, 0, 1, 4, F, D, er(3'b101), AWB, 0);
    tbl[5]  = mk(7'b0110011, 3'b110, 0, 1, 4, F, D, er(3'b011), AWB, 0);
    tbl[6]  = mk(7'b0110011, 3'b111, 1, 1, 4, F, D, er(3'b010), AWB, 0);
    tbl[7]  = mk(7'b0010011, 3'b000, 1, 1, 4, F, D, ei(3'b000), AWB, 0);
    tbl[8]  = mk(7'b0010011, 3'b110, 1, 1, 4, F, D, ei(3'b011), AWB, 0);
    tbl[9]  = mk(7'b1100011, 3'b000, 0, 1, 3, F, D, bq(1'b1), 0, 0);
    tbl[10] = mk(7'b1100011, 3'b000, 0, 0, 3, F, D, bq(1'b0), 0, 0);
    tbl[11] = mk(7'b1101111, 3'b000, 0, 1, 4, F, D, J, AWB, 0);
    rst[0] = 1'b1; rst[1] = 1'b1; rst[2] = 1'b1;
    op = 7'b0; funct3 = 3'b0; funct7b5 = 1'b0; zero = 1'b0;
    @(negedge clk); @(negedge clk);
    #1 chk("reset_gate", 0, act(0), FN);
    @(negedge clk);
    rst[0] = 1'b0;
    for (int i = 0; i < 12; i++) begin
      op = tbl[i].op; funct3 = tbl[i].f3; funct7b5 = tbl[i].f7; zero = tbl[i].z;
      for (int k = 0; k < int'(tbl[i].n); k++) q.push_back(tbl[i].e[k]);
      run($sformatf("vec%0d", i), 0, int'(tbl[i].n));
    end
    ill_seq("ill_op", 7'b1111111, 3'b000);
    ill_seq("ill_beq_f3", 7'b1100011, 3'b001);
    ill_seq("ill_r_f3", 7'b0110011, 3'b001);
    op = 7'b0000011; funct3 = 3'b010; zero = 1'b1;
    rst[1] = 1'b0;
    q.push_back(FN); q.push_back(FN); q.push_back(F); q.push_back(D); q.push_back(MAL); q.push_back(MR);
    run("ml3_lw", 1, 6);
    rst[1] = 1'b1;
    q.push_back(MR); q.push_back(FN);
    run("ml3_rst_dwell", 1, 2);
    rst[1] = 1'b0;
    q.push_back(FN); q.push_back(FN); q.push_back(F); q.push_back(D);
    run("ml3_refetch", 1, 4);
    rst[1] = 1'b1;
    rst[2] = 1'b0;
    for (int k = 0; k < 3; k++) q.push_back(FN);
    q.push_back(F); q.push_back(D); q.push_back(MAL);
    for (int k = 0; k < 4; k++) q.push_back(MR);
    q.push_back(MWB); q.push_back(FN);
    run("ml4_lw", 2, 12);
    rst[2] = 1'b1;
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
